// File: rtl/v_red_pkg.sv
// Shared encodings and element-wise helpers for the vector reduction pipeline.
package v_red_pkg;

  typedef enum logic [2:0] {
    OP_RSV  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_MINU = 3'b100,
    OP_MIN  = 3'b101,
    OP_MAXU = 3'b110,
    OP_MAX  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef struct packed {
    logic        valid;
    logic        start;
    logic        last;
    op_e         op;
    sew_e        sew;
    logic [63:0] seed;
  } ctl_t;

  function automatic int unsigned sew_bits(sew_e s);
    return 32'd8 << s;
  endfunction

  function automatic logic [63:0] sew_mask(sew_e s);
    case (s)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Identity element replicated across all SEW lanes of a 64-bit word.
  function automatic logic [63:0] identity(op_e op, sew_e sew);
    logic [63:0] top;
    int unsigned ew;
    ew = sew_bits(sew);
    for (int unsigned j = 0; j < 64; j++) top[j] = (((j + 1) & (ew - 1)) == 0);
    case (op)
      OP_AND, OP_MINU: return '1;
      OP_MIN:          return ~top;
      OP_MAX:          return top;
      default:         return '0;
    endcase
  endfunction

  // Operates on the low SEW bits of a and b; result is zero above SEW.
  function automatic logic [63:0] elem_op(op_e op, sew_e sew, logic [63:0] a, logic [63:0] b);
    logic [63:0]        m, ua, ub, res;
    logic signed [63:0] sa, sb;
    int unsigned        sh;
    m  = sew_mask(sew);
    sh = 64 - sew_bits(sew);
    ua = a & m;
    ub = b & m;
    sa = $signed(a << sh) >>> sh;
    sb = $signed(b << sh) >>> sh;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MINU: res = (ua < ub) ? a : b;
      OP_MIN:  res = (sa < sb) ? a : b;
      OP_MAXU: res = (ua > ub) ? a : b;
      OP_MAX:  res = (sa > sb) ? a : b;
      default: res = '0;
    endcase
    return res & m;
  endfunction

  function automatic logic [63:0] combine(op_e op, sew_e sew, logic [63:0] a, logic [63:0] b);
    logic [63:0] res;
    int unsigned ew;
    ew  = sew_bits(sew);
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i * ew < 64) res = res | (elem_op(op, sew, a >> (i * ew), b >> (i * ew)) << (i * ew));
    end
    return res;
  endfunction

endpackage

// File: rtl/v_red_fold_stage.sv
// One registered halving stage: upper and lower halves combined lane-wise at the current SEW.
module v_red_fold_stage
  import v_red_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 64,
  localparam int unsigned HALF = IN_WIDTH / 2,
  localparam int unsigned IW   = (IN_WIDTH > 64) ? IN_WIDTH : 64,
  localparam int unsigned OW   = (HALF > 64) ? HALF : 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] i_vec,
  input  ctl_t          i_ctl,
  output logic [OW-1:0] o_vec,
  output ctl_t          o_ctl
);

  logic [OW-1:0] w_vec;
  logic [OW-1:0] r_vec;
  ctl_t          r_ctl;

  generate
    if (HALF >= 64) begin : g_wide
      always_comb begin
        w_vec = '0;
        for (int unsigned c = 0; c < HALF / 64; c++)
          w_vec[c*64 +: 64] = combine(i_ctl.op, i_ctl.sew, i_vec[HALF + c*64 +: 64], i_vec[c*64 +: 64]);
      end
    end else begin : g_narrow
      // Below 64 bits the word stays 64 wide so an element wider than the half passes intact.
      logic [63:0] w_comb;
      always_comb begin
        w_comb = combine(i_ctl.op, i_ctl.sew, 64'(i_vec[IN_WIDTH-1:HALF]), 64'(i_vec[HALF-1:0]));
        if (sew_bits(i_ctl.sew) > HALF) w_vec = i_vec;
        else                            w_vec = {i_vec[63:HALF], w_comb[HALF-1:0]};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= '0;
      r_ctl <= '0;
    end else begin
      r_vec <= w_vec;
      r_ctl <= i_ctl;
    end
  end

  assign o_vec = r_vec;
  assign o_ctl = r_ctl;

endmodule

// File: rtl/v_red_logic_minmax.sv
// Pipelined vector reduction (and/or/xor/min/max) with masking, scalar seed and framed beats.
module v_red_logic_minmax
  import v_red_pkg::*;
#(
  parameter int unsigned REQ_DATA_WIDTH  = 64,
  parameter int unsigned RESP_DATA_WIDTH = 64,
  parameter int unsigned OPSEL_WIDTH     = 3,
  parameter int unsigned SEW_WIDTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_DATA_WIDTH-1:0]   in_vec0,
  input  logic [63:0]                 in_seed,
  input  logic [REQ_DATA_WIDTH/8-1:0] in_mask,
  input  logic                        in_valid,
  input  logic                        in_start,
  input  logic                        in_end,
  input  logic [OPSEL_WIDTH-1:0]      in_opSel,
  input  logic [SEW_WIDTH-1:0]        in_sew,
  output logic [RESP_DATA_WIDTH-1:0]  out_vec,
  output logic                        out_valid
);

  localparam int unsigned NB  = REQ_DATA_WIDTH / 8;
  localparam int unsigned NST = $clog2(NB);

  op_e                       w_op;
  sew_e                      w_sew;
  logic [63:0]               w_id;
  logic [REQ_DATA_WIDTH-1:0] w_masked;
  ctl_t                      w_ctl;
  logic [REQ_DATA_WIDTH-1:0] r_s0_vec;
  ctl_t                      r_s0_ctl;

  // Masked lanes take the op identity; byte k belongs to element k >> sew.
  always_comb begin
    w_op     = op_e'(in_opSel);
    w_sew    = sew_e'(in_sew);
    w_id     = identity(w_op, w_sew);
    w_masked = '0;
    for (int unsigned k = 0; k < NB; k++)
      w_masked[k*8 +: 8] = in_mask[k >> in_sew] ? in_vec0[k*8 +: 8] : w_id[(k % 8)*8 +: 8];
    w_ctl = '{valid: in_valid, start: in_start, last: in_end, op: w_op, sew: w_sew, seed: in_seed};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_vec <= '0;
      r_s0_ctl <= '0;
    end else begin
      r_s0_vec <= w_masked;
      r_s0_ctl <= w_ctl;
    end
  end

  logic [REQ_DATA_WIDTH-1:0] w_fvec [NST+1];
  ctl_t                      w_fctl [NST+1];

  assign w_fvec[0] = r_s0_vec;
  assign w_fctl[0] = r_s0_ctl;

  for (genvar k = 0; k < NST; k++) begin : g_fold
    localparam int unsigned IN = REQ_DATA_WIDTH >> k;
    localparam int unsigned IW = (IN > 64) ? IN : 64;
    localparam int unsigned OW = (IN / 2 > 64) ? IN / 2 : 64;
    logic [OW-1:0] w_o;
    v_red_fold_stage #(.IN_WIDTH(IN)) u_fold (
      .clk   (clk),
      .rst   (rst),
      .i_vec (w_fvec[k][IW-1:0]),
      .i_ctl (w_fctl[k]),
      .o_vec (w_o),
      .o_ctl (w_fctl[k+1])
    );
    assign w_fvec[k+1] = REQ_DATA_WIDTH'(w_o);
  end

  ctl_t        w_c;
  logic [63:0] w_f, w_a, w_res;
  op_e         w_aop;
  sew_e        w_asew;
  logic        w_take;
  logic [63:0] r_acc;
  op_e         r_op;
  sew_e        r_sew;
  logic        r_in_frame;
  logic        r_fire;

  // op/sew latched on the start beat govern the whole frame.
  always_comb begin
    w_c    = w_fctl[NST];
    w_f    = w_fvec[NST][63:0];
    w_a    = w_c.start ? w_c.seed : r_acc;
    w_aop  = w_c.start ? w_c.op   : r_op;
    w_asew = w_c.start ? w_c.sew  : r_sew;
    w_res  = combine(w_aop, w_asew, w_a, w_f);
    w_take = w_c.valid && (w_c.start || r_in_frame);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_op       <= OP_RSV;
      r_sew      <= SEW_8;
      r_in_frame <= 1'b0;
      r_fire     <= 1'b0;
    end else begin
      r_fire <= w_take && w_c.last;
      if (w_take) begin
        r_acc      <= w_res;
        r_op       <= w_aop;
        r_sew      <= w_asew;
        r_in_frame <= !w_c.last;
      end
    end
  end

  logic [RESP_DATA_WIDTH-1:0] r_out_vec;
  logic                       r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vec   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_fire;
      r_out_vec   <= r_fire ? RESP_DATA_WIDTH'(r_acc & sew_mask(r_sew)) : '0;
    end
  end

  assign out_vec   = r_out_vec;
  assign out_valid = r_out_valid;

endmodule
